// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
// Requester count, select width and arbiter state encoding.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux_8to1_w.sv
// Parameterised-width 8:1 data select.
// Pure datapath; select comes from the arbiter's registered sel.
module mux_8to1_w
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [N_REQ*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [WIDTH-1:0]       data_o
);

  // Slice out the lane addressed by sel_i.
  always_comb begin
    data_o = data_i[sel_i*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit channel among 8 requesters.
// Registered sel/gnt, bounded bursts, rotating priority pointer.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   out_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             xfer;
  logic             at_max;
  logic [SEL_W-1:0] pick;

  // First set request scanning from ptr upward, wrapping mod 8.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [SEL_W-1:0] p
  );
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Output handshake for the granted lane only.
  always_comb begin
    out_valid = (state_q == ST_BUSY) & gnt_q[sel_q] & req[sel_q];
    out_last  = out_valid & last[sel_q];
    xfer      = out_valid & out_ready;
    at_max    = (cnt_q == 4'(HOLD_MAX - 1));
    pick      = rr_pick(req, ptr_q);
  end

  // Next-state: grant in IDLE, count beats and release in BUSY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          sel_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          cnt_d       = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (last[sel_q] || at_max) begin
            gnt_d   = '0;
            ptr_d   = sel_q + 3'd1;
            state_d = ST_IDLE;
          end
        end else if (!req[sel_q]) begin
          gnt_d   = '0;
          ptr_d   = sel_q + 3'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  mux_8to1_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .data_i(data_in),
    .sel_i (sel_q),
    .data_o(out_data)
  );

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares the 8:1 4-bit output multiplexer among eight requesters. It registers the 3-bit select and a one-hot grant, and holds each grant for a bounded burst of beats under a valid/ready handshake. Rotating priority prevents starvation. The block sits between the requester-side data sources and a single downstream 4-bit channel.

## Interface
- `WIDTH`, 4: data bits per requester and output width.
- `HOLD_MAX`, 4: maximum beats per grant before forced rotation; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input 8: `req[i]` means requester i has a beat pending.
- `last` input 8: `last[i]` means requester i's current beat is the final beat of its burst.
- `data_in` input 8*WIDTH: packed; requester i occupies `[i*WIDTH +: WIDTH]`.
- `out_ready` input 1: downstream accepts a beat this cycle.
- `gnt` output 8: one-hot registered grant; all zeros when idle.
- `sel` output 3: registered mux select, equal to the index of the granted requester.
- `out_valid` output 1: `gnt[sel] & req[sel]` while in BUSY.
- `out_data` output WIDTH: `data_in` slice selected by `sel`; combinational from registered `sel`.
- `out_last` output 1: `last[sel]` while `out_valid`; otherwise 0.

## Operation
- State register has two states, IDLE and BUSY.
- Internal registers:
  - `ptr[2:0]`: highest-priority index.
  - `cnt[3:0]`: beats transferred in the current grant.
- IDLE:
  - If `req` is nonzero, select the first set bit scanning ptr, ptr+1, …, ptr+7, all indices mod 8.
  - Load that index into `sel`, set the matching `gnt` bit, clear `cnt`, and go to BUSY.
  - If `req` is zero, stay in IDLE with outputs unchanged.
- BUSY:
  - A beat transfers when `out_valid & out_ready`; on each transfer, `cnt` increments.
  - The grant ends when any of these holds:
    - (a) a transfer occurs with `last[sel]` = 1;
    - (b) a transfer occurs with `cnt` == HOLD_MAX-1;
    - (c) `req[sel]` = 0 with no transfer that cycle.
  - On grant end: `gnt` becomes 0, `ptr` becomes `sel`+1 (mod 8, wraps 7 to 0), and the state returns to IDLE. `sel` keeps its value.
- `req[sel]` must be held high until its beat transfers. Dropping it is treated as abandonment, case (c), and the grant is released.
- Requests from non-granted indices are ignored while BUSY.
- When (a) and (b) occur on the same transfer, there is a single release with the same result.
- HOLD_MAX = 1 gives exactly one beat per grant.
- Mid-operation reset immediately forces IDLE, `gnt`=0, `sel`=0, `ptr`=0, `cnt`=0. Any in-flight beat is discarded without completing.

## Timing
- Reset values: `gnt`=8'h00, `sel`=3'd0, `out_valid`=0, `out_last`=0, `out_data` = requester 0 slice, `ptr`=0, `cnt`=0, state IDLE.
- Grant latency: `req` sampled at edge t in IDLE gives `gnt`/`sel` valid after edge t, so `out_valid` can be high in cycle t+1.
- Back-to-back grants always have one IDLE bubble cycle between the release edge and the next grant edge.
- Throughput inside a grant: one beat per cycle when `out_ready` is held high.
- `out_data`/`out_last`/`out_valid` are combinational on inputs for the granted index. There is no input-to-output path through arbitration logic.

## Structure
- Shared package `rr_arb_pkg`:
  - `N_REQ`=8 and `SEL_W`=3;
  - state encoding `ST_IDLE`=1'b0 and `ST_BUSY`=1'b1.
- Sub-module `mux_8to1_w`: parameterised-width 8:1 select. It holds the datapath only and is instantiated once, driven by `sel`.
- The rotating priority pick lives inline as a combinational function in the arbiter.

## Test plan
- **Single requester.** `req`=8'h04, `last[2]` on beat 3, `out_ready`=1 → `gnt`=8'h04 and `sel`=2 one cycle after `req`, with exactly 3 beats. `out_last` is high on beat 3, then `gnt`=0 and `ptr`=3.
- **Rotation and wrap.** `req`=8'hFF held, every beat has `last`=1 → grant order 0,1,…,7,0 with one bubble cycle between grants. `ptr` wraps 7 to 0.
- **Forced rotation.** HOLD_MAX=4, `req`=8'h03, `last`=0 → requester 0 gets 4 beats, requester 1 gets 4 beats, then requester 0 again.
- **Backpressure.** Toggle `out_ready` 1,0,0,1 with `req[5]` held → `cnt` advances only on ready cycles, and `out_data` stays stable on the `data_in[23:20]` value.
- **Abandon.** Requester 6 is granted and drops `req[6]` before any transfer → the grant is released the next edge with `cnt`=0 and `ptr`=7.
- **Reset mid-burst.** Assert `rst` asynchronously during beat 2 of requester 3 → `gnt`=0, `sel`=0, `out_valid`=0 immediately. After release with `req`=8'h09, requester 0 is granted first.
